lockpick_key_loader: RTL

//  Upstream feeder for the lockpick game core. Buffers host key bytes in a small FIFO and issues a one-cycle start.

---
 rtl/lockpick_key_loader_if.sv | 10 +
 rtl/lockpick_key_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lockpick_key_loader_if.sv
// Host key-byte stream into the lockpick key loader.
// The host drives the master side and the loader is the slave.
interface lockpick_key_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lockpick_key_loader.sv
// Buffers host key bytes and feeds them to the lockpick game core, then latches the verdict.
// Optional watchdog on the result wait is enabled by defining LOCKPICK_LOADER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for go; host bytes may still preload the FIFO
// START    | one-cycle game_start pulse to the core
// FEED     | popping FIFO bytes into the core until KEY_BYTES are sent
// WAIT_RES | counting result beats from the core
// DONE     | acting on the latched verdict (retry, count win, or stop)
module lockpick_key_loader #(
    parameter int FIFO_DEPTH     = 8,
    parameter int KEY_BYTES      = 64,
    parameter int RESULT_BYTES   = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   go,
    lockpick_key_loader_if.slave   host,
    output logic                   game_start,
    output logic                   game_in_en,
    output logic [7:0]             game_in_data,
    input  logic                   game_out_valid,
    input  logic [7:0]             game_out_data,
    input  logic [1:0]             game_status,
    output logic                   busy,
    output logic [1:0]             verdict,
    output logic                   verdict_pulse,
    output logic [7:0]             result_byte,
    output logic [7:0]             wins
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(KEY_BYTES + 1);
    localparam int BW = $clog2(RESULT_BYTES + 1);
    localparam logic [FW-1:0] FEED_LAST = FW'(KEY_BYTES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(RESULT_BYTES - 1);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
        begin : g_param_check
            $error("lockpick_key_loader: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, FEED, WAIT_RES, DONE} state_t;
    state_t state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, flush;
    logic [FW-1:0] feed_cnt;
    logic [BW-1:0] beat_cnt;

    assign host.in_ready = (count != CW'(FIFO_DEPTH));
    assign push          = host.in_valid && host.in_ready;
    assign pop           = (state == FEED) && (count != '0);
    assign busy          = (state != IDLE);

`ifdef LOCKPICK_LOADER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wdog;

    // Down-counter expires on the last of TIMEOUT_CYCLES beat-free cycles in WAIT_RES.
    assign flush = (state == WAIT_RES) && !game_out_valid && (wdog == '0);
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host.in_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            game_start    <= 1'b0;
            game_in_en    <= 1'b0;
            game_in_data  <= '0;
            verdict       <= '0;
            verdict_pulse <= 1'b0;
            result_byte   <= '0;
            wins          <= '0;
            feed_cnt      <= '0;
            beat_cnt      <= '0;
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
            wdog          <= '0;
`endif
        end else begin
            game_start    <= 1'b0;
            game_in_en    <= 1'b0;
            verdict_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        game_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    feed_cnt <= '0;
                    state    <= FEED;
                end
                FEED: begin
                    if (pop) begin
                        game_in_en   <= 1'b1;
                        game_in_data <= mem[rd_ptr];
                        feed_cnt     <= feed_cnt + FW'(1);
                        if (feed_cnt == FEED_LAST) begin
                            beat_cnt <= '0;
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
                            wdog     <= WD_LOAD;
`endif
                            state    <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    if (game_out_valid) begin
                        if (beat_cnt == '0) result_byte <= game_out_data;
                        beat_cnt <= beat_cnt + BW'(1);
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
                        wdog     <= WD_LOAD;
`endif
                        if (beat_cnt == BEAT_LAST) begin
                            verdict       <= game_status;
                            verdict_pulse <= 1'b1;
                            state         <= DONE;
                        end
                    end
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
                    else if (wdog == '0) begin
                        verdict       <= 2'b00;
                        verdict_pulse <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wdog <= wdog - WW'(1);
                    end
`endif
                end
                DONE: begin
                    case (verdict)
                        // The core has already returned to key-A input; keep feeding without a new start.
                        2'b01: begin
                            feed_cnt <= '0;
                            state    <= FEED;
                        end
                        2'b10: begin
                            if (wins != 8'hFF) wins <= wins + 8'd1;
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
